// File: rtl/div32_seq.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one trial subtraction per clock,
// signed operands handled as magnitudes with a final sign fix, busy/done handshakes.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz_pend;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;

  assign w_a_mag  = (sign && a[WIDTH-1]) ? -a : a;
  assign w_b_mag  = (sign && b[WIDTH-1]) ? -b : b;
  assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = w_shift[WIDTH-1:0] - r_dvs;
  assign w_borrow = (w_shift < {1'b0, r_dvs});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_r       <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz_pend <= 1'b0;
      r_dz      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_dvd     <= w_a_mag;
            r_dvs     <= w_b_mag;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_neg_q   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r   <= sign & a[WIDTH-1];
            r_dz_pend <= (b == '0);
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (cancel) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // The dividend register doubles as the quotient shift register.
            if (w_borrow) begin
              r_rem <= w_shift[WIDTH-1:0];
              r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            end else begin
              r_rem <= w_diff;
              r_dvd <= {r_dvd[WIDTH-2:0], 1'b1};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_ITER)
              r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (cancel) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // Divide-by-zero keeps the all-ones quotient; negating the remainder restores a.
            r_q     <= (r_neg_q && !r_dz_pend) ? -r_dvd : r_dvd;
            r_r     <= r_neg_r ? -r_rem : r_rem;
            r_dz    <= r_dz_pend;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign q    = r_q;
  assign r    = r_r;
  assign dz   = r_dz;

endmodule
